// File: rtl/addr_data_serializer_pkg.sv
// Shared serializer/receiver definitions: FSM state encoding,
// field widths, sync length and the resulting frame length.
// ADDR_DATA_SERIALIZER_PARITY_EN adds one parity bit per frame.
package ptos_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ADDR,
        ST_DATA,
        ST_PAR
    } ptos_state_e;

    localparam int PTOS_ADDR_W      = 4;
    localparam int PTOS_DATA_W      = 4;
    localparam int PTOS_SYNC_CYCLES = 2;

`ifdef ADDR_DATA_SERIALIZER_PARITY_EN
    localparam int PTOS_PAR_BITS = 1;
`else
    localparam int PTOS_PAR_BITS = 0;
`endif

    localparam int PTOS_FRAME_LEN =
        PTOS_SYNC_CYCLES + PTOS_ADDR_W + PTOS_DATA_W + PTOS_PAR_BITS;

    function automatic int ptos_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/addr_data_serializer_if.sv
// Producer-side valid/ready bus of the serializer.
// Signals: in_valid, in_ready, addr_in, data_in.
// master = producer, slave = serializer.
interface addr_data_serializer_if
    import ptos_pkg::*;
#(
    parameter int ADDR_W = PTOS_ADDR_W,
    parameter int DATA_W = PTOS_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;

    modport master (
        output in_valid,
        output addr_in,
        output data_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  addr_in,
        input  data_in,
        output in_ready
    );
endinterface

// File: rtl/addr_data_serializer_hold_buf.sv
// One-entry holding register between producer and frame FSM.
// Ports: clk, rst, i_valid/o_ready/i_addr/i_data (producer side),
// i_take (FSM loads entry), o_full/o_addr/o_data (entry contents).
module serializer_hold_buf #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_take,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);
    logic              r_full;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_accept;

    // ready comes straight from a flop: no path from i_valid
    assign o_ready  = !r_full;
    assign w_accept = i_valid && !r_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            // a write in the same edge as a take keeps the entry full
            if (w_accept) begin
                r_full <= 1'b1;
                r_addr <= i_addr;
                r_data <= i_data;
            end else if (i_take) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_full = r_full;
    assign o_addr = r_addr;
    assign o_data = r_data;
endmodule

// File: rtl/addr_data_serializer.sv
// Frames buffered address/data pairs onto ena/p_out, LSB first.
// Ports: clk, rst, in_bus (slave handshake), ena, p_out, busy,
// frame_done. ADDR_DATA_SERIALIZER_PARITY_EN appends a parity bit.
module addr_data_serializer
    import ptos_pkg::*;
#(
    parameter int SYNC_CYCLES = PTOS_SYNC_CYCLES,
    parameter int ADDR_W      = PTOS_ADDR_W,
    parameter int DATA_W      = PTOS_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    addr_data_serializer_if.slave  in_bus,
    output logic                   ena,
    output logic                   p_out,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int SH_W  = ADDR_W + DATA_W;
    localparam int CNT_W =
        $clog2(ptos_max3(SYNC_CYCLES, ADDR_W, DATA_W) + 1);
    localparam logic [CNT_W-1:0] LAST_S = CNT_W'(SYNC_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_A = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_W - 1);

    ptos_state_e       r_state;
    ptos_state_e       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [SH_W-1:0]   r_shift;
    logic [SH_W-1:0]   w_shift_nxt;
    logic              r_ena;
    logic              r_pout;
    logic              r_done;
    logic              w_ena_nxt;
    logic              w_pout_nxt;
    logic              w_done_nxt;
    logic              w_load;
    logic              w_end;
    logic              w_full;
    logic              w_ready;
    logic [ADDR_W-1:0] w_hold_addr;
    logic [DATA_W-1:0] w_hold_data;
`ifdef ADDR_DATA_SERIALIZER_PARITY_EN
    logic              r_par;
    logic              w_par_nxt;
`endif

    serializer_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_bus.in_valid),
        .o_ready (w_ready),
        .i_addr  (in_bus.addr_in),
        .i_data  (in_bus.data_in),
        .i_take  (w_load),
        .o_full  (w_full),
        .o_addr  (w_hold_addr),
        .o_data  (w_hold_data)
    );

    assign in_bus.in_ready = w_ready;

    // Next-state: r_state/r_cnt describe the bit currently on the wire
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_end       = 1'b0;
`ifdef ADDR_DATA_SERIALIZER_PARITY_EN
        w_par_nxt   = r_par;
`endif
        unique case (r_state)
            ST_IDLE: w_load = w_full;
            ST_SYNC: begin
                if (r_cnt == LAST_S) begin
                    w_state_nxt = ST_ADDR;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_ADDR: begin
                w_shift_nxt = r_shift >> 1;
                if (r_cnt == LAST_A) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                w_shift_nxt = r_shift >> 1;
                if (r_cnt == LAST_D) begin
`ifdef ADDR_DATA_SERIALIZER_PARITY_EN
                    w_state_nxt = ST_PAR;
                    w_cnt_nxt   = '0;
`else
                    w_end = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_PAR:  w_end = 1'b1;
            default: w_state_nxt = ST_IDLE;
        endcase

        // end of frame: chain straight into the next one if queued
        if (w_end) begin
            w_load      = w_full;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end

        if (w_load) begin
            w_state_nxt = ST_SYNC;
            w_cnt_nxt   = '0;
            w_shift_nxt = {w_hold_data, w_hold_addr};
`ifdef ADDR_DATA_SERIALIZER_PARITY_EN
            w_par_nxt   = ^{w_hold_data, w_hold_addr};
`endif
        end
    end

    // Outputs are decoded from the next state so they can be flopped
    always_comb begin
        w_ena_nxt  = (w_state_nxt == ST_SYNC);
        w_pout_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (w_state_nxt == ST_ADDR || w_state_nxt == ST_DATA) begin
            w_pout_nxt = w_shift_nxt[0];
        end
`ifdef ADDR_DATA_SERIALIZER_PARITY_EN
        if (w_state_nxt == ST_PAR) begin
            w_pout_nxt = w_par_nxt;
            w_done_nxt = 1'b1;
        end
`else
        if (w_state_nxt == ST_DATA && w_cnt_nxt == LAST_D) begin
            w_done_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_ena   <= 1'b0;
            r_pout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_ena   <= w_ena_nxt;
            r_pout  <= w_pout_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef ADDR_DATA_SERIALIZER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else begin
            r_par <= w_par_nxt;
        end
    end
`endif

    assign ena        = r_ena;
    assign p_out      = r_pout;
    assign frame_done = r_done;
    assign busy       = (r_state != ST_IDLE);
endmodule
